dfil_ctrl: RTL and testbench

//  Sequencer and configuration front-end for the sliding-window pulse-density filter.
//  - Holds the runtime config: window length and hysteresis thresholds.
//  - Clears the filter, then waits one full window before trusting its running sum.
//  - Applies hysteresis to the sum and emits the debounced level.
//  - Reports each level change as a timestamped event over a valid/ready handshake.

---
 rtl/dfil_ctrl.sv | 129 ++++++++++++
 tb/tb_dfil_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dfil_ctrl.sv
// Sequencer and config front-end for the sliding-window pulse-density filter:
// clear/warm-up sequencing, hysteresis on the running sum, timestamped edge events.
module dfil_ctrl #(
  parameter int SUM_W      = 30,
  parameter int WIN_W      = 15,
  parameter int TS_W       = 32,
  parameter int CLR_CYCLES = 2,
  parameter int DEF_HI     = 4500,
  parameter int DEF_LO     = 500,
  parameter int DEF_WIN    = 5000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SUM_W-1:0] cfg_hi,
  input  logic [SUM_W-1:0] cfg_lo,
  input  logic [WIN_W-1:0] cfg_win,
  output logic             cfg_err,
  input  logic [SUM_W-1:0] sum_in,
  output logic             flt_clr,
  output logic             out,
  output logic             out_valid,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_dir,
  output logic [TS_W-1:0]  evt_ts,
  output logic             overflow
);

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, FILL, RUN} state_t;

  state_t             state, state_nxt;
  logic [CLR_W-1:0]   clr_cnt;
  logic [WIN_W-1:0]   fill_cnt;
  logic [SUM_W-1:0]   hi, lo;
  logic [WIN_W-1:0]   win;
  logic [TS_W-1:0]    ts;
  logic               clr_done, fill_done, cfg_ok, cfg_wr;
  logic               run_active, out_nxt, edge_det;

  assign clr_done   = (clr_cnt == CLR_W'(CLR_CYCLES - 1));
  assign fill_done  = (fill_cnt == win - WIN_W'(1));
  assign cfg_ready  = (state == IDLE);
  assign flt_clr    = (state == CLEAR);
  assign out_valid  = (state == RUN);
  assign cfg_wr     = cfg_valid && cfg_ready;
  assign cfg_ok     = (cfg_lo < cfg_hi) && (cfg_win != '0) && (cfg_hi <= SUM_W'(cfg_win));
  assign run_active = (state == RUN) && en;

  // Dropping en from any active state returns straight to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (en) state_nxt = CLEAR;
      CLEAR: if (!en) state_nxt = IDLE; else if (clr_done) state_nxt = FILL;
      FILL:  if (!en) state_nxt = IDLE; else if (fill_done) state_nxt = RUN;
      RUN:   if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Hysteresis; leaving RUN forces out low without reporting an edge.
  always_comb begin
    out_nxt = 1'b0;
    if (run_active) begin
      out_nxt = out;
      if (sum_in > hi)
        out_nxt = 1'b1;
      else if (sum_in < lo)
        out_nxt = 1'b0;
    end
  end

  assign edge_det = run_active && (out_nxt != out);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      fill_cnt <= '0;
      hi       <= SUM_W'(DEF_HI);
      lo       <= SUM_W'(DEF_LO);
      win      <= WIN_W'(DEF_WIN);
      cfg_err  <= 1'b0;
      out      <= 1'b0;
      ts       <= '0;
    end else begin
      state    <= state_nxt;
      clr_cnt  <= (state == CLEAR) ? clr_cnt + CLR_W'(1) : '0;
      fill_cnt <= (state == FILL) ? fill_cnt + WIN_W'(1) : '0;
      cfg_err  <= cfg_wr && !cfg_ok;
      if (cfg_wr && cfg_ok) begin
        hi  <= cfg_hi;
        lo  <= cfg_lo;
        win <= cfg_win;
      end
      out <= out_nxt;
      if (state == FILL && state_nxt == RUN)
        ts <= '0;
      else if (state == RUN)
        ts <= ts + TS_W'(1);
    end
  end

  // One-entry event buffer; an edge arriving while it is full and not draining is lost.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      evt_valid <= 1'b0;
      evt_dir   <= 1'b0;
      evt_ts    <= '0;
      overflow  <= 1'b0;
    end else begin
      if (edge_det && (!evt_valid || evt_ready)) begin
        evt_valid <= 1'b1;
        evt_dir   <= out_nxt;
        evt_ts    <= ts;
      end else if (edge_det) begin
        overflow <= 1'b1;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dfil_ctrl.sv
// Directed self-checking bench for dfil_ctrl: sequencing, config writes,
// hysteresis thresholds, event buffering/overflow and async reset.
module tb_dfil_ctrl;

  logic        CLK, RST, en, cfg_valid, cfg_ready, cfg_err;
  logic [29:0] cfg_hi, cfg_lo, sum_in;
  logic [14:0] cfg_win;
  logic        flt_clr, out, out_valid, evt_valid, evt_ready, evt_dir, overflow;
  logic [31:0] evt_ts;

  int vectors = 0;
  int fails   = 0;

  dfil_ctrl dut (
    .CLK(CLK), .RST(RST), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_hi(cfg_hi), .cfg_lo(cfg_lo), .cfg_win(cfg_win), .cfg_err(cfg_err),
    .sum_in(sum_in), .flt_clr(flt_clr), .out(out), .out_valid(out_valid),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_dir(evt_dir),
    .evt_ts(evt_ts), .overflow(overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_cfg(input int lo, input int hi, input int win);
    cfg_lo    = 30'(lo);
    cfg_hi    = 30'(hi);
    cfg_win   = 15'(win);
    cfg_valid = 1'b1;
  endtask

  initial begin
    RST = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_hi = '0; cfg_lo = '0; cfg_win = '0;
    sum_in = '0; evt_ready = 1'b0;
    tick(); tick();
    check_output("rst_cfg_ready", cfg_ready, 1);
    check_output("rst_flt_clr", flt_clr, 0);
    check_output("rst_out", out, 0);
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_evt_valid", evt_valid, 0);
    check_output("rst_overflow", overflow, 0);
    check_output("rst_cfg_err", cfg_err, 0);
    check_output("rst_evt_ts", evt_ts, 0);
    RST = 1'b0;

    // Default window of 5000: two clear cycles, then 5000 fill cycles
    en = 1'b1;
    tick(); check_output("clr_c1", flt_clr, 1);
    check_output("clr_cfg_ready", cfg_ready, 0);
    tick(); check_output("clr_c2", flt_clr, 1);
    tick(); check_output("fill_start_clr", flt_clr, 0);
    check_output("fill_start_valid", out_valid, 0);
    repeat (4999) tick();
    check_output("fill_last_valid", out_valid, 0);
    tick(); check_output("run_valid", out_valid, 1);

    // Default thresholds hi=4500 lo=500
    sum_in = 30'd4500; tick(); check_output("hi_eq_hold", out, 0);
    sum_in = 30'd4501; tick(); check_output("hi_gt_set", out, 1);
    check_output("evt1_valid", evt_valid, 1);
    check_output("evt1_dir", evt_dir, 1);
    check_output("evt1_ts", evt_ts, 1);
    evt_ready = 1'b1; sum_in = 30'd500; tick();
    check_output("lo_eq_hold", out, 1);
    check_output("evt1_taken", evt_valid, 0);
    evt_ready = 1'b0; sum_in = 30'd499; tick();
    check_output("lo_lt_clr", out, 0);
    check_output("evt2_dir", evt_dir, 0);
    check_output("evt2_ts", evt_ts, 3);
    evt_ready = 1'b1; tick(); check_output("evt2_taken", evt_valid, 0);

    // Edge coincident with a handshake replaces the pending event
    evt_ready = 1'b0; sum_in = 30'd4501; tick();
    check_output("evt3_dir", evt_dir, 1);
    check_output("evt3_ts", evt_ts, 5);
    evt_ready = 1'b1; sum_in = 30'd0; tick();
    check_output("evt4_valid", evt_valid, 1);
    check_output("evt4_dir", evt_dir, 0);
    check_output("evt4_ts", evt_ts, 6);
    check_output("evt4_no_ovf", overflow, 0);

    // Full buffer, two more edges: both dropped, payload frozen
    evt_ready = 1'b0; sum_in = 30'd4501; tick();
    check_output("drop1_out", out, 1);
    check_output("drop1_ovf", overflow, 1);
    check_output("drop1_dir", evt_dir, 0);
    check_output("drop1_ts", evt_ts, 6);
    sum_in = 30'd0; tick();
    check_output("drop2_ts", evt_ts, 6);
    check_output("drop2_valid", evt_valid, 1);

    // Leaving RUN: out forced low, no event, pending event survives
    en = 1'b0; tick();
    check_output("idle_out_valid", out_valid, 0);
    check_output("idle_cfg_ready", cfg_ready, 1);
    check_output("idle_evt_kept", evt_valid, 1);
    check_output("idle_evt_dir", evt_dir, 0);

    // Config writes in IDLE
    evt_ready = 1'b1;
    apply_cfg(600, 500, 5000); tick();
    check_output("bad_lo_hi_err", cfg_err, 1);
    check_output("evt_drain", evt_valid, 0);
    evt_ready = 1'b0; cfg_valid = 1'b0; tick();
    check_output("err_pulse_end", cfg_err, 0);
    apply_cfg(5, 25, 20); tick();
    check_output("bad_hi_win_err", cfg_err, 1);
    apply_cfg(5, 15, 0); tick();
    check_output("bad_win0_err", cfg_err, 1);
    apply_cfg(5, 15, 20); tick();
    check_output("good_cfg_err", cfg_err, 0);
    cfg_valid = 1'b0;

    // en dropped mid-FILL restarts the whole sequence
    en = 1'b1; tick(); tick(); tick();
    check_output("fill_a_clr", flt_clr, 0);
    repeat (5) tick();
    en = 1'b0; tick();
    check_output("abort_cfg_ready", cfg_ready, 1);
    check_output("abort_valid", out_valid, 0);
    en = 1'b1; tick(); check_output("re_clr1", flt_clr, 1);
    tick(); check_output("re_clr2", flt_clr, 1);
    tick(); check_output("re_fill", flt_clr, 0);
    repeat (19) tick();
    check_output("win20_not_yet", out_valid, 0);
    tick(); check_output("win20_run", out_valid, 1);

    // Config write in RUN must be ignored (hi=2 would set out on 15)
    apply_cfg(1, 2, 3);
    check_output("run_cfg_ready", cfg_ready, 0);
    sum_in = 30'd15; tick();
    check_output("run_cfg_err", cfg_err, 0);
    cfg_valid = 1'b0; tick();
    check_output("hi15_eq_hold", out, 0);
    sum_in = 30'd16; tick();
    check_output("hi15_set", out, 1);
    check_output("evt5_dir", evt_dir, 1);
    check_output("evt5_ts", evt_ts, 2);
    check_output("ovf_sticky", overflow, 1);
    sum_in = 30'd4; tick();
    check_output("lo5_clr", out, 0);
    check_output("evt5_frozen", evt_dir, 1);
    sum_in = 30'd16; tick();
    check_output("pre_rst_out", out, 1);

    // Asynchronous reset between clock edges
    #2 RST = 1'b1;
    #1;
    check_output("arst_out", out, 0);
    check_output("arst_valid", out_valid, 0);
    check_output("arst_evt", evt_valid, 0);
    check_output("arst_ovf", overflow, 0);
    check_output("arst_cfg_ready", cfg_ready, 1);
    en = 1'b0; sum_in = '0;
    tick();
    RST = 1'b0;
    tick();
    check_output("post_rst_flt_clr", flt_clr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
